// File: rtl/lcd_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_responder
// Purpose  : HD44780-style 2x16 character display model that sits on the LCD
//            bus, decodes instruction/data writes and exposes its buffer.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic [4:0] rd_index,
    output logic [7:0] rd_char,
    output logic [4:0] cursor_index,
    output logic       display_on,
    output logic       busy,
    output logic       char_wr,
    output logic       protocol_err
);

    localparam int                 c_depth      = 32;
    localparam int                 c_cnt_w      = $clog2(CLEAR_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_busy_load  = c_cnt_w'(BUSY_CYCLES);
    localparam logic [c_cnt_w-1:0] c_clear_load = c_cnt_w'(CLEAR_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [7:0]         c_blank      = 8'h20;

    logic                 r_en_s1, r_en_s2, r_en_s3;
    logic                 r_rs_s1, r_rs_s2;
    logic                 r_rw_s1, r_rw_s2;
    logic [7:0]           r_data_s1, r_data_s2;

    logic [4:0]           r_cursor;
    logic                 r_inc;
    logic                 r_display_on;
    logic [c_cnt_w-1:0]   r_busy_cnt;
    logic                 r_char_wr;
    logic                 r_protocol_err;
    logic [7:0]           r_rd_char;

    logic                 w_strobe;
    logic                 w_busy;
    logic                 w_wr;
    logic                 w_accept;
    logic                 w_data_wr;
    logic                 w_clear;
    logic [4:0]           w_cursor_nxt;
    logic                 w_inc_nxt;
    logic                 w_disp_nxt;
    logic                 w_err_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_depth-1:0][7:0] w_buf;

    // Bus inputs are asynchronous to CLOCK_50; EN gets an extra stage for edge detect.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_en_s1   <= 1'b0;
            r_en_s2   <= 1'b0;
            r_en_s3   <= 1'b0;
            r_rs_s1   <= 1'b0;
            r_rs_s2   <= 1'b0;
            r_rw_s1   <= 1'b0;
            r_rw_s2   <= 1'b0;
            r_data_s1 <= 8'h00;
            r_data_s2 <= 8'h00;
        end else begin
            r_en_s1   <= LCD_EN;
            r_en_s2   <= r_en_s1;
            r_en_s3   <= r_en_s2;
            r_rs_s1   <= LCD_RS;
            r_rs_s2   <= r_rs_s1;
            r_rw_s1   <= LCD_RW;
            r_rw_s2   <= r_rw_s1;
            r_data_s1 <= LCD_DATA;
            r_data_s2 <= r_data_s1;
        end
    end

    always_comb begin
        w_strobe     = r_en_s3 & ~r_en_s2;
        w_busy       = (r_busy_cnt != '0);
        w_wr         = w_strobe & ~r_rw_s2;
        w_accept     = w_wr & ~w_busy;
        w_data_wr    = 1'b0;
        w_clear      = 1'b0;
        w_cursor_nxt = r_cursor;
        w_inc_nxt    = r_inc;
        w_disp_nxt   = r_display_on;
        w_err_nxt    = r_protocol_err | (w_wr & w_busy);
        w_cnt_nxt    = w_busy ? (r_busy_cnt - c_cnt_one) : r_busy_cnt;

        if (w_accept) begin
            if (r_rs_s2) begin
                // 5-bit wrap gives 31->0 / 0->31; 15<->16 is the natural line crossing.
                w_data_wr    = 1'b1;
                w_cursor_nxt = r_inc ? (r_cursor + 5'd1) : (r_cursor - 5'd1);
                w_cnt_nxt    = c_busy_load;
            end else begin
                casez (r_data_s2)
                    8'b1???_????: begin
                        w_cnt_nxt = c_busy_load;
                        if (r_data_s2[6:4] == 3'b000) begin
                            w_cursor_nxt = {1'b0, r_data_s2[3:0]};
                        end else if (r_data_s2[6:4] == 3'b100) begin
                            w_cursor_nxt = {1'b1, r_data_s2[3:0]};
                        end else begin
                            w_cursor_nxt = 5'd0;
                            w_err_nxt    = 1'b1;
                        end
                    end
                    8'b01??_????,
                    8'b001?_????,
                    8'b0001_????: begin
                        w_cnt_nxt = c_busy_load;
                    end
                    8'b0000_1???: begin
                        w_disp_nxt = r_data_s2[2];
                        w_cnt_nxt  = c_busy_load;
                    end
                    8'b0000_01??: begin
                        w_inc_nxt = r_data_s2[1];
                        w_cnt_nxt = c_busy_load;
                    end
                    8'b0000_001?: begin
                        w_cursor_nxt = 5'd0;
                        w_cnt_nxt    = c_clear_load;
                    end
                    8'b0000_0001: begin
                        w_clear      = 1'b1;
                        w_cursor_nxt = 5'd0;
                        w_inc_nxt    = 1'b1;
                        w_cnt_nxt    = c_clear_load;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_depth; gi++) begin : g_cell
            logic [7:0] r_cell;
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_cell <= c_blank;
                end else if (w_clear) begin
                    r_cell <= c_blank;
                end else if (w_data_wr && (r_cursor == 5'(gi))) begin
                    r_cell <= r_data_s2;
                end
            end
            assign w_buf[gi] = r_cell;
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cursor       <= 5'd0;
            r_inc          <= 1'b1;
            r_display_on   <= 1'b0;
            r_busy_cnt     <= '0;
            r_char_wr      <= 1'b0;
            r_protocol_err <= 1'b0;
            r_rd_char      <= c_blank;
        end else begin
            r_cursor       <= w_cursor_nxt;
            r_inc          <= w_inc_nxt;
            r_display_on   <= w_disp_nxt;
            r_busy_cnt     <= w_cnt_nxt;
            r_char_wr      <= w_data_wr;
            r_protocol_err <= w_err_nxt;
            r_rd_char      <= w_buf[rd_index];
        end
    end

    assign rd_char      = r_rd_char;
    assign cursor_index = r_cursor;
    assign display_on   = r_display_on;
    assign busy         = w_busy;
    assign char_wr      = r_char_wr;
    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Synthesizable model of the HD44780-style character display on the far end of the DE2 LCD bus, used on-chip for self-checking the LCD controller.
- Observes LCD_EN/LCD_RS/LCD_RW/LCD_DATA and decodes instructions and data writes.
- Maintains a 32-character display buffer for a 2x16 display, with cursor and busy timing.
- Exposes the buffer through an index/ascii read port, mirroring the controller's lcd_index/lcd_ascii pairing.

Parameters:
- BUSY_CYCLES, 2000, CLOCK_50 cycles busy after any accepted instruction or data write other than clear/home.
- CLEAR_CYCLES, 82000, CLOCK_50 cycles busy after clear display or return home.

Ports:
- CLOCK_50  input  1  50 MHz clock.
- RESET_N  input  1  Asynchronous, active-low reset.
- LCD_EN  input  1  Bus enable strobe from the controller.
- LCD_RS  input  1  0 = instruction, 1 = data.
- LCD_RW  input  1  0 = write, 1 = read.
- LCD_DATA  input  8  Bus data. This block never drives it.
- rd_index  input  5  Buffer read address: 0-15 is line 1, 16-31 is line 2.
- rd_char  output  8  Buffer contents at rd_index, registered.
- cursor_index  output  5  Current write position.
- display_on  output  1  D bit of the last display on/off command.
- busy  output  1  Model busy flag.
- char_wr  output  1  One-cycle pulse when a data write lands in the buffer.
- protocol_err  output  1  Sticky error flag, cleared only by reset.

Behaviour:
- Reset (async, RESET_N=0):
  - All 32 buffer entries = 0x20.
  - cursor_index = 0, increment mode = 1.
  - display_on, busy, char_wr, protocol_err = 0.
  - rd_char = 0x20; synchronizers = 0.
  - Reset asserted mid-busy or mid-strobe aborts everything, with no partial write.
- Input capture:
  - EN, RS, RW and DATA each pass through a 2-flop synchronizer; EN has a third flop.
  - A strobe is EN sync stage2 = 0 and stage3 = 1, i.e. the falling edge.
  - RS/RW/DATA are taken from stage2 in the same cycle.
  - Effects (buffer, cursor, flags, char_wr) become visible at the next clock edge, 3 CLOCK_50 edges after the EN pin falls.
- Strobe with RW=1: no state change, not an error (reads are not modelled).
- Strobe with RW=0 while busy=1: ignored and protocol_err set.
- Accepted instruction decode (RS=0, RW=0, busy=0), priority from MSB:
  - 1xxxxxxx, set DDRAM address A=DATA[6:0]:
    - 0x00-0x0F gives cursor A.
    - 0x40-0x4F gives cursor 16+(A-0x40).
    - Any other value gives cursor 0 and sets protocol_err.
  - 01xxxxxx (CGRAM address): no effect.
  - 001xxxxx (function set): no effect other than busy.
  - 0001xxxx (cursor/display shift): no effect other than busy.
  - 00001DCB: display_on = D.
  - 000001IS: increment mode = I. S is ignored.
  - 0000001x (return home): cursor = 0, busy for CLEAR_CYCLES.
  - 00000001 (clear): all entries = 0x20 in one cycle, cursor = 0, increment mode = 1, busy for CLEAR_CYCLES.
  - 00000000: no effect, no busy, not an error.
- Accepted data write (RS=1, RW=0, busy=0):
  - buffer[cursor_index] = DATA; char_wr pulses for 1 cycle.
  - Cursor then moves.
    - Increment mode: 15→16, 31→0, otherwise +1.
    - Decrement mode: 0→31, 16→15, otherwise -1.
- Busy counter:
  - Loaded on the acceptance edge, so busy=1 from the following cycle.
  - Lasts exactly BUSY_CYCLES or CLEAR_CYCLES cycles, then busy=0.
  - A strobe on the first cycle busy=0 is accepted.
- Read port:
  - rd_char = buffer[rd_index] registered with 1-cycle latency.
  - A same-cycle write to the same index returns the old value; the new value appears one cycle later.
- Counter widths: busy counter is ceil(log2(CLEAR_CYCLES+1)) bits. No arithmetic overflow is possible.

Test Plan:
- Reset, then sweep rd_index 0-31 → rd_char = 0x20 on every index; cursor_index=0, busy=0, protocol_err=0.
- Instruction 0x0C, then data 'H' (0x48) and 'i' (0x69), with waits ≥ BUSY_CYCLES between strobes → display_on=1; buffer[0]=0x48, buffer[1]=0x69; cursor_index=2; two char_wr pulses; busy high for exactly 2000 cycles after each strobe.
- Set address 0x4F, write 0x41, write 0x42 → buffer[31]=0x41, buffer[0]=0x42 (wrap); cursor_index=1. Then set address 0x20 → cursor 0 and protocol_err=1.
- Fill 32 chars, then instruction 0x01 → all entries 0x20 one cycle after acceptance; cursor 0; busy for 82000 cycles. A data strobe at cycle 100 of busy is ignored and sets protocol_err.
- Entry mode 0x04, set address 0x40, write 0x58 → buffer[16]=0x58, cursor 15. An RW=1 strobe in between → no change, no error.
- Assert RESET_N low during the busy window of a clear → all outputs back to reset values immediately; first strobe after release is accepted.
